// File: rtl/video_sync_pkg.sv
// rtl/video_sync_pkg.sv - shared state encoding, counter widths and saturation limits for video frame sync
package video_sync_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        FILL   = 3'd2,
        RUN    = 3'd3,
        RESYNC = 3'd4
    } state_t;

    localparam int UF_CNT_W     = 16;
    localparam int RESYNC_CNT_W = 8;
    localparam int DELAY_CNT_W  = 20;
    localparam int GOOD_CNT_W   = 4;

    typedef logic [UF_CNT_W-1:0]     uf_cnt_t;
    typedef logic [RESYNC_CNT_W-1:0] rs_cnt_t;
    typedef logic [DELAY_CNT_W-1:0]  delay_t;
    typedef logic [GOOD_CNT_W-1:0]   good_t;

    localparam uf_cnt_t UF_CNT_MAX     = 16'hFFFF;
    localparam rs_cnt_t RESYNC_CNT_MAX = 8'hFF;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - optional N-flop synchroniser followed by a registered rising-edge pulse
module sync_edge_det #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic synced;
    logic prev_q;

    generate
        if (DEPTH == 0) begin : g_direct
            assign synced = din;
        end else begin : g_sync
            logic [DEPTH-1:0] sync_q;

            // shift the raw input through DEPTH flops to settle metastability
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= (sync_q << 1) | DEPTH'(din);
                end
            end

            assign synced = sync_q[DEPTH-1];
        end
    endgenerate

    // one-cycle registered pulse on a 0->1 transition of the settled signal
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            prev_q <= synced;
            rise   <= synced & ~prev_q;
        end
    end

endmodule

// File: rtl/video_frame_sync_ctrl.sv
// rtl/video_frame_sync_ctrl.sv - camera/display frame sequencer and phase-lock supervisor (option: VIDEO_UNDERFLOW_RESYNC_EN)
module video_frame_sync_ctrl
    import video_sync_pkg::*;
#(
    parameter int FLUSH_CYCLES = 8,
    parameter int START_DELAY  = 1024,
    parameter int LOCK_FRAMES  = 4
) (
    input  logic          video_clk,
    input  logic          rst,
    input  logic          cam_vs,
    input  logic          fifo_empty,
    input  logic          tg_vs,
    input  logic          tg_de,
    output logic          tg_rst,
    output logic          fifo_rst,
    output logic          locked,
    output logic [15:0]   underflow_cnt,
    output logic [7:0]    resync_cnt
);

    localparam delay_t FLUSH_LOAD = delay_t'(FLUSH_CYCLES);
    localparam delay_t FILL_LOAD  = delay_t'(START_DELAY);
    localparam good_t  LOCK_VAL   = good_t'(LOCK_FRAMES);

    logic   cam_rise;
    logic   tg_rise;
    state_t state_q, state_d;
    delay_t dly_q, dly_d;
    logic [1:0] win_q, win_d, win_sum;
    logic   first_q, first_d;
    good_t  good_q, good_d;
    logic   uf_event;

    sync_edge_det #(.DEPTH(2)) u_cam_edge (
        .clk  (video_clk),
        .rst  (rst),
        .din  (cam_vs),
        .rise (cam_rise)
    );

    sync_edge_det #(.DEPTH(0)) u_tg_edge (
        .clk  (video_clk),
        .rst  (rst),
        .din  (tg_vs),
        .rise (tg_rise)
    );

    assign uf_event = (state_q == RUN) && tg_de && fifo_empty;

    // state, phase-window and delay counter registers
    always_ff @(posedge video_clk) begin
        if (rst) begin
            state_q <= IDLE;
            dly_q   <= '0;
            win_q   <= '0;
            first_q <= 1'b0;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            win_q   <= win_d;
            first_q <= first_d;
            good_q  <= good_d;
        end
    end

    // next-state: sequencing countdowns and the per-frame tg_vs phase check
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        win_d   = win_q;
        first_d = first_q;
        good_d  = good_q;
        // a tg_rise coincident with cam_rise belongs to the window being closed
        win_sum = win_q + {1'b0, tg_rise};
        case (state_q)
            IDLE: begin
                if (cam_rise) begin
                    state_d = FLUSH;
                    dly_d   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (dly_q <= delay_t'(1)) begin
                    state_d = FILL;
                    dly_d   = FILL_LOAD;
                end else begin
                    dly_d = dly_q - delay_t'(1);
                end
            end
            FILL: begin
                // a zero delay still spends one cycle here
                if (dly_q <= delay_t'(1)) begin
                    state_d = RUN;
                    win_d   = '0;
                    first_d = 1'b1;
                end else begin
                    dly_d = dly_q - delay_t'(1);
                end
            end
            RUN: begin
                if (cam_rise) begin
                    win_d = '0;
                    if (first_q) begin
                        first_d = 1'b0;
                    end else if (win_sum == 2'd1) begin
                        if (good_q != LOCK_VAL) begin
                            good_d = good_q + good_t'(1);
                        end
                    end else begin
                        state_d = RESYNC;
                    end
                end else begin
                    win_d = (win_sum == 2'd3) ? 2'd2 : win_sum;
                end
`ifdef VIDEO_UNDERFLOW_RESYNC_EN
                if (uf_event) begin
                    state_d = RESYNC;
                end
`else
`endif
            end
            RESYNC: begin
                state_d = IDLE;
                good_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // registered outputs follow the state one cycle later; counters saturate
    always_ff @(posedge video_clk) begin
        if (rst) begin
            tg_rst        <= 1'b0;
            fifo_rst      <= 1'b0;
            locked        <= 1'b0;
            underflow_cnt <= '0;
            resync_cnt    <= '0;
        end else begin
            tg_rst   <= (state_q == RUN);
            fifo_rst <= (state_q == FLUSH);
            locked   <= (state_q == RUN) && (good_q == LOCK_VAL);
            if (uf_event && (underflow_cnt != UF_CNT_MAX)) begin
                underflow_cnt <= underflow_cnt + 16'd1;
            end
            if ((state_q == RESYNC) && (resync_cnt != RESYNC_CNT_MAX)) begin
                resync_cnt <= resync_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_frame_sync_ctrl.sv
// tb/tb_video_frame_sync_ctrl.sv - self-checking bench for video_frame_sync_ctrl (default and short-sequence instances)
`timescale 1ns/1ps
module tb_video_frame_sync_ctrl;

    localparam int LOCK = 4;
    localparam int M_IDLE = 0, M_FLUSH = 1, M_FILL = 2, M_RUN = 3, M_RESYNC = 4;

    logic video_clk = 1'b0;
    logic rst = 1'b1;
    logic cam_vs = 1'b0;
    logic fifo_empty = 1'b0;
    logic tg_vs = 1'b0;
    logic tg_de = 1'b0;

    logic tg_rst_a, fifo_rst_a, locked_a;
    logic [15:0] uf_a;
    logic [7:0]  rs_a;
    logic tg_rst_b, fifo_rst_b, locked_b;
    logic [15:0] uf_b;
    logic [7:0]  rs_b;

    video_frame_sync_ctrl dut_a (
        .video_clk     (video_clk),
        .rst           (rst),
        .cam_vs        (cam_vs),
        .fifo_empty    (fifo_empty),
        .tg_vs         (tg_vs),
        .tg_de         (tg_de),
        .tg_rst        (tg_rst_a),
        .fifo_rst      (fifo_rst_a),
        .locked        (locked_a),
        .underflow_cnt (uf_a),
        .resync_cnt    (rs_a)
    );

    video_frame_sync_ctrl #(.FLUSH_CYCLES(1), .START_DELAY(0), .LOCK_FRAMES(LOCK)) dut_b (
        .video_clk     (video_clk),
        .rst           (rst),
        .cam_vs        (cam_vs),
        .fifo_empty    (fifo_empty),
        .tg_vs         (tg_vs),
        .tg_de         (tg_de),
        .tg_rst        (tg_rst_b),
        .fifo_rst      (fifo_rst_b),
        .locked        (locked_b),
        .underflow_cnt (uf_b),
        .resync_cnt    (rs_b)
    );

    always #5 video_clk = ~video_clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // model state, one slot per instance
    int p_flush [2] = '{8, 1};
    int p_delay [2] = '{1024, 0};
    int m_mode [2];
    int m_left [2];
    int m_win  [2];
    int m_good [2];
    bit m_first[2];
    bit e_tg [2];
    bit e_fr [2];
    bit e_lk [2];
    int e_uf [2];
    int e_rs [2];
    bit cam_h [4];
    bit tg_h  [2];
    bit cam_vis = 1'b0;
    bit tg_vis  = 1'b0;

    int fr_rise = -1, fr_fall = -1, tga_rise = -1, tgb_rise = -1;
    bit p_fr = 1'b0, p_tga = 1'b0, p_tgb = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit cr, tr;
        int wsum;
        cr = cam_vis;
        tr = tg_vis;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mode[i] = M_IDLE; m_left[i] = 0; m_win[i] = 0; m_good[i] = 0; m_first[i] = 0;
                e_tg[i] = 0; e_fr[i] = 0; e_lk[i] = 0; e_uf[i] = 0; e_rs[i] = 0;
            end else begin
                e_tg[i] = (m_mode[i] == M_RUN);
                e_fr[i] = (m_mode[i] == M_FLUSH);
                e_lk[i] = (m_mode[i] == M_RUN) && (m_good[i] == LOCK);
                if (m_mode[i] == M_RUN && tg_de && fifo_empty && e_uf[i] < 65535) e_uf[i]++;
                if (m_mode[i] == M_RESYNC && e_rs[i] < 255) e_rs[i]++;
                case (m_mode[i])
                    M_IDLE: if (cr) begin m_mode[i] = M_FLUSH; m_left[i] = p_flush[i]; end
                    M_FLUSH: begin
                        m_left[i]--;
                        if (m_left[i] == 0) begin
                            m_mode[i] = M_FILL;
                            m_left[i] = (p_delay[i] == 0) ? 1 : p_delay[i];
                        end
                    end
                    M_FILL: begin
                        m_left[i]--;
                        if (m_left[i] == 0) begin m_mode[i] = M_RUN; m_win[i] = 0; m_first[i] = 1; end
                    end
                    M_RUN: begin
                        wsum = m_win[i] + int'(tr);
                        if (cr) begin
                            if (m_first[i]) m_first[i] = 0;
                            else if (wsum == 1) m_good[i] = (m_good[i] < LOCK) ? m_good[i] + 1 : LOCK;
                            else m_mode[i] = M_RESYNC;
                            m_win[i] = 0;
                        end else begin
                            m_win[i] = wsum;
                        end
`ifdef VIDEO_UNDERFLOW_RESYNC_EN
                        if (tg_de && fifo_empty) m_mode[i] = M_RESYNC;
`endif
                    end
                    default: begin m_mode[i] = M_IDLE; m_good[i] = 0; end
                endcase
            end
        end
        if (rst) begin
            for (int j = 0; j < 4; j++) cam_h[j] = 0;
            tg_h[0] = 0; tg_h[1] = 0;
        end else begin
            for (int j = 3; j > 0; j--) cam_h[j] = cam_h[j-1];
            cam_h[0] = cam_vs;
            tg_h[1] = tg_h[0];
            tg_h[0] = tg_vs;
        end
        cam_vis = cam_h[2] && !cam_h[3];
        tg_vis  = tg_h[0] && !tg_h[1];
    endtask

    initial forever begin
        @(posedge video_clk);
        cyc++;
        model_step();
    end

    initial forever begin
        @(negedge video_clk);
        if (cyc >= 1) begin
            chk("model_a", {5'b0, tg_rst_a, fifo_rst_a, locked_a, uf_a, rs_a},
                {5'b0, e_tg[0], e_fr[0], e_lk[0], 16'(e_uf[0]), 8'(e_rs[0])});
            chk("model_b", {5'b0, tg_rst_b, fifo_rst_b, locked_b, uf_b, rs_b},
                {5'b0, e_tg[1], e_fr[1], e_lk[1], 16'(e_uf[1]), 8'(e_rs[1])});
            if (fifo_rst_a && !p_fr) fr_rise = cyc;
            if (!fifo_rst_a && p_fr) fr_fall = cyc;
            if (tg_rst_a && !p_tga) tga_rise = cyc;
            if (tg_rst_b && !p_tgb) tgb_rise = cyc;
            p_fr = fifo_rst_a; p_tga = tg_rst_a; p_tgb = tg_rst_b;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge video_clk);
        #1;
    endtask

    task automatic cam_pulse(output int k);
        cam_vs = 1'b1;
        k = cyc + 1;
        tick(4);
        cam_vs = 1'b0;
    endtask

    task automatic tg_pulse();
        tg_vs = 1'b1;
        tick(2);
        tg_vs = 1'b0;
    endtask

    initial begin
        int k, kd;
        tick(5);
        rst = 1'b0;
        chk("reset_tg_rst", {31'b0, tg_rst_a}, 32'd0);
        chk("reset_fifo_rst", {31'b0, fifo_rst_a}, 32'd0);
        chk("reset_locked", {31'b0, locked_a}, 32'd0);
        chk("reset_counts", {8'b0, uf_a, rs_a}, 32'd0);
        tick(3);

        // initial sequence with cam pulses landing in FLUSH and FILL
        cam_pulse(k);
        tick(2);
        cam_pulse(kd);
        tick(400);
        cam_pulse(kd);
        tick(700);
        chk("flush_start", fr_rise, k + 4);
        chk("flush_len", fr_fall - fr_rise, 8);
        chk("start_delay", tga_rise - fr_fall, 1024);
        chk("short_seq_tg_rst", tgb_rise, k + 6);

        // steady frames: first cam_rise exempt, then four good frames
        for (int f = 0; f < 5; f++) begin
            if (f == 4) chk("not_locked_before_5th", {31'b0, locked_a}, 32'd0);
            cam_pulse(kd);
            tick(10);
            tg_pulse();
            tick(10);
        end
        chk("locked_after_5th", {31'b0, locked_a}, 32'd1);
        chk("no_resync", {24'b0, rs_a}, 32'd0);

        // drop one tg_vs
        cam_pulse(kd);
        tick(20);
        cam_pulse(k);
        chk("still_locked_pre_resync", {31'b0, locked_a}, 32'd1);
        tick(1);
        chk("resync_locked", {31'b0, locked_a}, 32'd0);
        chk("resync_tg_rst", {31'b0, tg_rst_a}, 32'd0);
        chk("resync_cnt", {24'b0, rs_a}, 32'd1);
        tick(5);
        cam_pulse(k);
        tick(1100);
        chk("reseq_flush_start", fr_rise, k + 4);
        chk("reseq_flush_len", fr_fall - fr_rise, 8);
        chk("reseq_delay", tga_rise - fr_fall, 1024);

        // underflow
        tg_de = 1'b1;
        fifo_empty = 1'b1;
        tick(10);
        tg_de = 1'b0;
`ifdef VIDEO_UNDERFLOW_RESYNC_EN
        chk("uf_single", {16'b0, uf_a}, 32'd1);
        chk("uf_resync", {24'b0, rs_a}, 32'd2);
`else
        chk("uf_ten", {16'b0, uf_a}, 32'd10);
        tg_de = 1'b1;
        tick(70000);
        tg_de = 1'b0;
        chk("uf_saturate", {16'b0, uf_a}, 32'h0000FFFF);
        chk("run_before_rst", {31'b0, tg_rst_a}, 32'd1);
`endif
        fifo_empty = 1'b0;

        // reset mid-operation
        rst = 1'b1;
        tick(1);
        chk("midrst_a", {5'b0, tg_rst_a, fifo_rst_a, locked_a, uf_a, rs_a}, 32'd0);
        chk("midrst_b", {5'b0, tg_rst_b, fifo_rst_b, locked_b, uf_b, rs_b}, 32'd0);
        rst = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
